// File: rtl/uart_alu_host_if_pkg.sv
// rtl/uart_alu_host_if_pkg.sv - shared state encoding and default widths for the UART ALU host sequencer
package uart_alu_host_if_pkg;

  localparam int DBIT_DEF  = 8;
  localparam int NB_OP_DEF = 6;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SEND = 3'd4
  } state_t;

  // States in which the sequencer pops the RX FIFO
  function automatic logic is_rx_state(input state_t s);
    return (s == S_A) || (s == S_B) || (s == S_OP);
  endfunction

endpackage

// File: rtl/uart_alu_host_if_if.sv
// rtl/uart_alu_host_if_if.sv - RX/TX FIFO handshake bundle between the sequencer (master) and UART FIFOs (slave)
interface uart_alu_host_if_if
  import uart_alu_host_if_pkg::*;
#(
  parameter int DBIT = DBIT_DEF
) ();

  logic            rx_empty;
  logic [DBIT-1:0] r_data;
  logic            rd_uart;
  logic            tx_full;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;

  modport master (
    input  rx_empty,
    input  r_data,
    input  tx_full,
    output rd_uart,
    output wr_uart,
    output w_data
  );

  modport slave (
    output rx_empty,
    output r_data,
    output tx_full,
    input  rd_uart,
    input  wr_uart,
    input  w_data
  );

endinterface

// File: rtl/uart_if_timeout.sv
// rtl/uart_if_timeout.sv - inter-byte idle counter; expire is a combinational strobe on the last allowed idle cycle
module uart_if_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TIMEOUT_BITS-1:0] LAST =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_BITS'(TIMEOUT_CYCLES - 1) : '0;

  logic [TIMEOUT_BITS-1:0] cnt;

  // A zero cycle budget disables expiry entirely
  assign expire = (TIMEOUT_CYCLES != 0) && en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TIMEOUT_BITS'(1);
    end
  end

endmodule

// File: rtl/uart_alu_host_if.sv
// rtl/uart_alu_host_if.sv - collects A/B/opcode frames from the RX FIFO, runs the ALU and returns one result byte
module uart_alu_host_if
  import uart_alu_host_if_pkg::*;
#(
  parameter int DBIT           = DBIT_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic              i_clk,
  input  logic              reset,
  uart_alu_host_if_if.master fifo,
  output logic [DBIT-1:0]   o_alu_a,
  output logic [DBIT-1:0]   o_alu_b,
  output logic [NB_OP-1:0]  o_alu_op,
  input  logic [DBIT-1:0]   i_alu_result,
  output logic              o_busy,
  output logic              o_timeout
);

  state_t          state;
  state_t          state_nx;
  logic            rd;
  logic            wr;
  logic            tmo_en;
  logic            tmo_clr;
  logic            tmo_expire;
  logic [DBIT-1:0] result;

  assign tmo_en = ((state == S_B) || (state == S_OP)) && fifo.rx_empty;

  uart_if_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_BITS  (TIMEOUT_BITS)
  ) u_timeout (
    .clk   (i_clk),
    .rst   (reset),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .expire(tmo_expire)
  );

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state <= S_A;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rd       = 1'b0;
    wr       = 1'b0;
    tmo_clr  = 1'b0;
    case (state)
      S_A: begin
        tmo_clr = 1'b1;
        rd      = !fifo.rx_empty;
        if (rd) state_nx = S_B;
      end
      S_B, S_OP: begin
        // An arriving byte takes priority over an expiring counter
        if (!fifo.rx_empty) begin
          rd       = 1'b1;
          tmo_clr  = 1'b1;
          state_nx = (state == S_B) ? S_OP : S_EXEC;
        end else if (tmo_expire) begin
          state_nx = S_A;
        end
      end
      S_EXEC: begin
        tmo_clr  = 1'b1;
        state_nx = S_SEND;
      end
      S_SEND: begin
        tmo_clr = 1'b1;
        wr      = !fifo.tx_full;
        if (wr) state_nx = S_A;
      end
      default: state_nx = S_A;
    endcase
  end

  // Strobes are masked while reset is held so the FIFOs are left untouched
  assign fifo.rd_uart = rd && !reset && is_rx_state(state);
  assign fifo.wr_uart = wr && !reset;
  assign fifo.w_data  = result;
  assign o_busy       = (state != S_A);
  assign o_timeout    = tmo_expire && !reset;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      o_alu_a  <= '0;
      o_alu_b  <= '0;
      o_alu_op <= '0;
      result   <= '0;
    end else begin
      if (rd) begin
        case (state)
          S_A:     o_alu_a  <= fifo.r_data;
          S_B:     o_alu_b  <= fifo.r_data;
          S_OP:    o_alu_op <= fifo.r_data[NB_OP-1:0];
          default: ;
        endcase
      end
      if (state == S_EXEC) begin
        result <= i_alu_result;
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_host_if.sv
// tb/tb_uart_alu_host_if.sv - randomized and directed bench with FIFO/ALU models and a frame-level scoreboard
module tb_uart_alu_host_if;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] alu_result;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  uart_alu_host_if_if #(.DBIT(8)) fifo ();

  uart_alu_host_if #(
    .DBIT          (8),
    .NB_OP         (6),
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_BITS  (5)
  ) dut (
    .i_clk       (clk),
    .reset       (reset),
    .fifo        (fifo),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .o_alu_op    (alu_op),
    .i_alu_result(alu_result),
    .o_busy      (busy),
    .o_timeout   (timeout)
  );

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b[2:0]);
      6'h02:   return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu(alu_a, alu_b, alu_op);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] expq[$];
  logic       txf = 1'b0;
  logic       rand_bp = 1'b0;
  int cyc = 0;
  int pop_total = 0;
  int last_pop_cyc = 0;
  int wr_total = 0;
  int last_wr_cyc = 0;
  int tmo_total = 0;
  int last_tmo_cyc = 0;

  task automatic drive();
    fifo.rx_empty = (rxq.size() == 0);
    fifo.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
    fifo.tx_full  = txf;
  endtask

  // One clock: sample mid-cycle, then apply FIFO/TX effects of the edge at the next negedge
  task automatic tick();
    logic       rd;
    logic       wr;
    logic       tmo;
    logic [7:0] wd;
    #1;
    rd  = fifo.rd_uart;
    wr  = fifo.wr_uart;
    tmo = timeout;
    wd  = fifo.w_data;
    check("rd_on_empty", int'(rd & fifo.rx_empty), 0);
    check("wr_on_full", int'(wr & fifo.tx_full), 0);
    @(negedge clk);
    if (rd) begin
      if (rxq.size() != 0) void'(rxq.pop_front());
      pop_total++;
      last_pop_cyc = cyc;
    end
    if (wr) begin
      txq.push_back(wd);
      wr_total++;
      last_wr_cyc = cyc;
    end
    if (tmo) begin
      tmo_total++;
      last_tmo_cyc = cyc;
    end
    cyc++;
    if (rand_bp) txf = ($urandom_range(0, 3) == 0);
    drive();
  endtask

  task automatic wait_pops(input int n, input int budget);
    int target;
    int k;
    target = pop_total + n;
    k = 0;
    while (pop_total < target && k < budget) begin
      tick();
      k++;
    end
    check("pop_wait", int'(pop_total >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((rxq.size() != 0 || busy) && k < budget) begin
      tick();
      k++;
    end
    check("idle_wait", int'(rxq.size() == 0 && !busy), 1);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    rxq.push_back(a);
    rxq.push_back(b);
    rxq.push_back(op);
    expq.push_back(alu(a, b, op[5:0]));
    drive();
  endtask

  task automatic check_tx(input string tag);
    check({tag, "_count"}, txq.size(), expq.size());
    for (int i = 0; i < txq.size() && i < expq.size(); i++) begin
      check({tag, "_data"}, int'(txq[i]), int'(expq[i]));
    end
    txq.delete();
    expq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int t0;
    int w0;
    int changes;
    logic [7:0] wd0;
    logic [7:0] ops [8];
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;

    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    reset = 1'b1;
    drive();
    repeat (3) @(negedge clk);
    rxq.push_back(8'hAA);
    drive();
    #1;
    check("rst_rd", int'(fifo.rd_uart), 0);
    check("rst_wr", int'(fifo.wr_uart), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tmo", int'(timeout), 0);
    check("rst_a", int'(alu_a), 0);
    check("rst_b", int'(alu_b), 0);
    check("rst_op", int'(alu_op), 0);
    check("rst_wdata", int'(fifo.w_data), 0);
    rxq.delete();
    @(negedge clk);
    reset = 1'b0;
    drive();
    tick();

    // ADD frame and latency
    send_frame(8'h05, 8'h03, 8'h20);
    wait_idle(50);
    check("add_latency", last_wr_cyc - last_pop_cyc, 2);
    check("add_op", int'(alu_op), 'h20);
    check("add_wdata", int'(fifo.w_data), 'h08);
    check_tx("add");

    // Opcode upper bits ignored
    send_frame(8'hF0, 8'h0F, 8'hE4);
    wait_idle(50);
    check("upper_op", int'(alu_op), 'h24);
    check("upper_wdata", int'(fifo.w_data), 'h00);
    check_tx("upper");

    // TX backpressure
    txf = 1'b1;
    send_frame(8'h12, 8'h34, 8'h20);
    wait_pops(3, 20);
    tick();
    wd0 = fifo.w_data;
    w0 = wr_total;
    changes = 0;
    repeat (50) begin
      tick();
      if (fifo.w_data !== wd0) changes++;
    end
    check("bp_no_wr", wr_total - w0, 0);
    check("bp_stable", changes, 0);
    check("bp_wdata", int'(wd0), 'h46);
    txf = 1'b0;
    drive();
    tick();
    check("bp_release", wr_total - w0, 1);
    check("bp_release_cyc", last_wr_cyc, cyc - 1);
    repeat (3) tick();
    check("bp_single", wr_total - w0, 1);
    check_tx("bp");

    // Partial frame timeout
    t0 = tmo_total;
    w0 = wr_total;
    rxq.push_back(8'h11);
    drive();
    wait_pops(1, 10);
    p = last_pop_cyc;
    for (int k = 0; k < 40 && tmo_total == t0; k++) tick();
    check("tmo_count", tmo_total - t0, 1);
    check("tmo_delay", last_tmo_cyc - p, 16);
    repeat (3) tick();
    check("tmo_idle", int'(busy), 0);
    check("tmo_no_wr", wr_total - w0, 0);
    check("tmo_a_kept", int'(alu_a), 'h11);
    check("tmo_single", tmo_total - t0, 1);
    send_frame(8'h02, 8'h02, 8'h20);
    wait_idle(50);
    check("tmo_next_wdata", int'(fifo.w_data), 'h04);
    check_tx("tmo");

    // Byte arriving exactly on the expiry cycle
    t0 = tmo_total;
    rxq.push_back(8'h33);
    drive();
    wait_pops(1, 10);
    p = last_pop_cyc;
    while (cyc < p + 16) tick();
    rxq.push_back(8'h44);
    drive();
    tick();
    check("col_pop_cyc", last_pop_cyc, p + 16);
    check("col_no_tmo", tmo_total - t0, 0);
    check("col_b", int'(alu_b), 'h44);
    rxq.push_back(8'h22);
    expq.push_back(alu(8'h33, 8'h44, 6'h22));
    drive();
    wait_idle(50);
    check("col_tmo_after", tmo_total - t0, 0);
    check("col_wdata", int'(fifo.w_data), 'hEF);
    check_tx("col");

    // Randomized frames with gaps and TX backpressure
    rand_bp = 1'b1;
    for (int f = 0; f < 25; f++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = ops[$urandom_range(0, 7)] | {2'($urandom), 6'h00};
      expq.push_back(alu(a, b, op[5:0]));
      rxq.push_back(a);
      drive();
      repeat ($urandom_range(0, 8)) tick();
      rxq.push_back(b);
      drive();
      repeat ($urandom_range(0, 8)) tick();
      rxq.push_back(op);
      drive();
      repeat ($urandom_range(0, 4)) tick();
    end
    rand_bp = 1'b0;
    txf = 1'b0;
    drive();
    wait_idle(400);
    check("rand_tmo", tmo_total, 1);
    check_tx("rand");

    // Asynchronous reset in S_OP
    w0 = wr_total;
    rxq.push_back(8'h77);
    rxq.push_back(8'h66);
    drive();
    wait_pops(2, 10);
    check("pre_rst_busy", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_a", int'(alu_a), 0);
    check("arst_b", int'(alu_b), 0);
    check("arst_wdata", int'(fifo.w_data), 0);
    repeat (3) tick();
    reset = 1'b0;
    drive();
    repeat (5) tick();
    check("arst_no_stale", wr_total - w0, 0);
    send_frame(8'h01, 8'h01, 8'h20);
    wait_idle(50);
    check("arst_wr_once", wr_total - w0, 1);
    check("arst_wdata_after", int'(fifo.w_data), 'h02);
    check_tx("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
